// File: rtl/wsg_pkg.sv
// wsg_pkg
//   Shared constants for the Namco 8-voice wavetable sound generator.
//   Holds the accumulator width, the frame/slot timing, the per-voice
//   register offsets inside each 8-byte voice block, and the slot phase type.
package wsg_pkg;

   localparam int NUM_VOICES   = 8;
   localparam int ACC_W        = 20;
   localparam int FRAME_CYCLES = 256;
   localparam int SLOT_CYCLES  = 4;

   // Byte offsets within a voice's 8-byte register block.
   localparam logic [2:0] REG_F0  = 3'd0;   // freq[7:0]
   localparam logic [2:0] REG_F1  = 3'd1;   // freq[15:8]
   localparam logic [2:0] REG_F2W = 3'd2;   // {-, wave[2:0], freq[19:16]}
   localparam logic [2:0] REG_VOL = 3'd3;   // {----, vol[3:0]}

   // Phase of the 4-cycle voice slot, taken straight from cnt[1:0].
   typedef enum logic [1:0] {
      PH_ACC  = 2'd0,   // step accumulator
      PH_ADDR = 2'd1,   // issue wave ROM address
      PH_MAC  = 2'd2,   // accumulate sample * volume
      PH_IDLE = 2'd3
   } phase_t;

endpackage

// File: rtl/wsg_voice_regs.sv
// wsg_voice_regs
//   Sound register file for the eight voices. Captures one sub-CPU write per
//   rising edge of the level strobe WE and offers a combinational read of one
//   voice's fields selected by RD_SEL.
// Ports:
//   CLK24M, nRESET      clock, asynchronous active-low reset
//   ADDR[5:0], DATA[7:0] write address / data; ADDR[5:3] = voice, ADDR[2:0] = offset
//   WE                  level write strobe, held for several cycles per write
//   RD_SEL[2:0]         voice selected for readout
//   RD_FREQ, RD_WAVE, RD_VOL  selected voice's frequency, wave number, volume
module wsg_voice_regs
   import wsg_pkg::*;
(
   input  logic             CLK24M,
   input  logic             nRESET,
   input  logic [5:0]       ADDR,
   input  logic [7:0]       DATA,
   input  logic             WE,
   input  logic [2:0]       RD_SEL,
   output logic [ACC_W-1:0] RD_FREQ,
   output logic [2:0]       RD_WAVE,
   output logic [3:0]       RD_VOL
);

   logic             we_d;
   logic             wr_stb;
   logic [2:0]       wr_voice;
   logic [2:0]       wr_off;
   logic [ACC_W-1:0] freq [NUM_VOICES];
   logic [2:0]       wave [NUM_VOICES];
   logic [3:0]       vol  [NUM_VOICES];

   // No register field uses DATA bit 7.
   logic unused_data_b7;
   assign unused_data_b7 = DATA[7];

   // Only the first cycle of a held strobe writes; later cycles are ignored
   // even if DATA changes underneath.
   assign wr_stb   = WE & ~we_d;
   assign wr_voice = ADDR[5:3];
   assign wr_off   = ADDR[2:0];

   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         we_d <= 1'b0;
      end else begin
         we_d <= WE;
      end
   end

   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            freq[v] <= '0;
            wave[v] <= '0;
            vol[v]  <= '0;
         end
      end else if (wr_stb) begin
         case (wr_off)
            REG_F0:  freq[wr_voice][7:0]   <= DATA;
            REG_F1:  freq[wr_voice][15:8]  <= DATA;
            REG_F2W: begin
               freq[wr_voice][19:16] <= DATA[3:0];
               wave[wr_voice]        <= DATA[6:4];
            end
            REG_VOL: vol[wr_voice] <= DATA[3:0];
            default: ;
         endcase
      end
   end

   assign RD_FREQ = freq[RD_SEL];
   assign RD_WAVE = wave[RD_SEL];
   assign RD_VOL  = vol[RD_SEL];

endmodule

// File: rtl/namco_wsg8.sv
// namco_wsg8
//   Eight-voice Namco wavetable sound generator. A free-running frame counter
//   walks the voices in 4-cycle slots during cnt 0..31: step the voice's
//   20-bit phase accumulator, fetch its 4-bit sample from the external wave
//   ROM, and accumulate sample*volume. At cnt 32 the mix is latched to SOUT.
// Ports:
//   CLK24M, nRESET      clock, asynchronous active-low reset
//   ADDR, DATA, WE      sub-CPU writes into the $00-$3F sound register window
//   SND_ENABLE          forces SOUT to zero at the next latch when low
//   WAVE_CLK            wave ROM clock (CLK24M)
//   WAVE_AD[7:0]        wave ROM address {wave, sample index}
//   WAVE_DT[3:0]        wave ROM data, valid one cycle after the address
//   SOUT[7:0]           mixed unsigned output, updated once per frame
module namco_wsg8 #(
   parameter int NUM_VOICES   = 8,
   parameter int FRAME_CYCLES = 256
) (
   input  logic       CLK24M,
   input  logic       nRESET,
   input  logic [5:0] ADDR,
   input  logic [7:0] DATA,
   input  logic       WE,
   input  logic       SND_ENABLE,
   output logic       WAVE_CLK,
   output logic [7:0] WAVE_AD,
   input  logic [3:0] WAVE_DT,
   output logic [7:0] SOUT
);

   import wsg_pkg::*;

   localparam logic [7:0] SCAN_END = 8'(NUM_VOICES * SLOT_CYCLES);
   localparam logic [7:0] CNT_LAST = 8'(FRAME_CYCLES - 1);

   logic [7:0]       cnt;
   logic [2:0]       slot;
   phase_t           phase;
   logic             in_scan;
   logic             latch_now;
   logic [ACC_W-1:0] acc [NUM_VOICES];
   logic [ACC_W-1:0] acc_next;
   logic [10:0]      sum;
   logic [7:0]       mac_prod;
   logic [ACC_W-1:0] rd_freq;
   logic [2:0]       rd_wave;
   logic [3:0]       rd_vol;

   assign WAVE_CLK = CLK24M;

   assign slot      = cnt[4:2];
   assign phase     = phase_t'(cnt[1:0]);
   assign in_scan   = (cnt < SCAN_END);
   assign latch_now = (cnt == SCAN_END);

   wsg_voice_regs u_regs (
      .CLK24M  (CLK24M),
      .nRESET  (nRESET),
      .ADDR    (ADDR),
      .DATA    (DATA),
      .WE      (WE),
      .RD_SEL  (slot),
      .RD_FREQ (rd_freq),
      .RD_WAVE (rd_wave),
      .RD_VOL  (rd_vol)
   );

   // Accumulator wraps mod 2^20 by width truncation.
   assign acc_next = acc[slot] + rd_freq;
   assign mac_prod = {4'd0, WAVE_DT} * {4'd0, rd_vol};

   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            acc[v] <= '0;
         end
      end else if (in_scan && phase == PH_ACC) begin
         acc[slot] <= acc_next;
      end
   end

   // Address uses the accumulator already stepped in the previous cycle.
   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         WAVE_AD <= '0;
      end else if (in_scan && phase == PH_ADDR) begin
         WAVE_AD <= {rd_wave, acc[slot][ACC_W-1:ACC_W-5]};
      end
   end

   // Worst case 8 * 15 * 15 = 1800 fits the 11-bit sum; SOUT takes sum/8.
   always_ff @(posedge CLK24M or negedge nRESET) begin
      if (!nRESET) begin
         sum  <= '0;
         SOUT <= '0;
      end else if (latch_now) begin
         SOUT <= SND_ENABLE ? sum[10:3] : 8'h00;
         sum  <= '0;
      end else if (in_scan && phase == PH_MAC) begin
         sum <= sum + {3'd0, mac_prod};
      end
   end

endmodule

// File: tb/tb_namco_wsg8.sv
// tb_namco_wsg8
//   Directed self-checking bench for namco_wsg8. Models the wave ROM
//   (wave 0 = triangle ramp, wave 7 = all 0xF) and checks SOUT, WAVE_AD and
//   the frame counter / accumulator against hand-derived values.
module tb_namco_wsg8;

   logic       clk;
   logic       n_reset;
   logic [5:0] addr;
   logic [7:0] data;
   logic       we;
   logic       snd_enable;
   logic       wave_clk;
   logic [7:0] wave_ad;
   logic [3:0] wave_dt;
   logic [7:0] sout;

   int n_checks;
   int n_fail;

   logic [3:0]  rom [256];
   logic [19:0] exp_acc7;
   logic [19:0] freq_fs [8];

   namco_wsg8 dut (
      .CLK24M     (clk),
      .nRESET     (n_reset),
      .ADDR       (addr),
      .DATA       (data),
      .WE         (we),
      .SND_ENABLE (snd_enable),
      .WAVE_CLK   (wave_clk),
      .WAVE_AD    (wave_ad),
      .WAVE_DT    (wave_dt),
      .SOUT       (sout)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wave ROM: address registered mid-cycle so data issued at P1 is ready
   // at the P2 edge.
   always @(negedge clk) wave_dt <= rom[wave_ad];

   function automatic int ramp(input int k);
      int i;
      i = k % 32;
      return (i < 16) ? i : 31 - i;
   endfunction

   // Driver tasks
   task automatic do_reset();
      n_reset = 1'b0;
      we      = 1'b0;
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
   endtask

   task automatic wait_cnt(input logic [7:0] target);
      int n;
      n = 0;
      @(negedge clk);
      while (dut.cnt !== target && n < 600) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (dut.cnt !== target) begin
         n_fail++;
         $display("FAIL wait_cnt: cnt=%0d required %0d within 600 cycles", dut.cnt, target);
      end
   endtask

   task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
      addr = a;
      data = d;
      we   = 1'b1;
      repeat (3) @(negedge clk);
      we = 1'b0;
      @(negedge clk);
   endtask

   // Scenario tasks
   task automatic test_reset();
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (sout !== 8'h00) begin n_fail++; $display("FAIL reset_sout: got %0d required 0", sout); end
      n_checks++;
      if (wave_ad !== 8'h00) begin n_fail++; $display("FAIL reset_wave_ad: got %0h required 0", wave_ad); end
      n_checks++;
      if (dut.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", dut.cnt); end
      n_reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut.cnt !== 8'd1) begin n_fail++; $display("FAIL reset_cnt_start: got %0d required 1", dut.cnt); end
      for (int f = 0; f < 3; f++) begin
         wait_cnt(8'd33);
         n_checks++;
         if (sout !== 8'h00) begin n_fail++; $display("FAIL idle_sout: frame %0d got %0d required 0", f, sout); end
         n_checks++;
         if (wave_ad !== 8'h00) begin n_fail++; $display("FAIL idle_wave_ad: frame %0d got %0h required 0", f, wave_ad); end
      end
   endtask

   task automatic test_single_voice();
      logic [7:0] exp;
      do_reset();
      wait_cnt(8'd40);
      write_reg(6'h00, 8'h00);
      write_reg(6'h01, 8'h80);
      write_reg(6'h02, 8'h00);
      write_reg(6'h03, 8'h0F);
      for (int k = 1; k <= 20; k++) begin
         wait_cnt(8'd33);
         exp = 8'((15 * ramp(k)) >> 3);
         n_checks++;
         if (sout !== exp) begin
            n_fail++;
            $display("FAIL single_voice: frame %0d got %0d required %0d", k, sout, exp);
         end
      end
   endtask

   task automatic test_full_scale();
      do_reset();
      wait_cnt(8'd40);
      for (int v = 0; v < 8; v++) begin
         freq_fs[v] = 20'((v + 1) * 32'h08000 + v);
         write_reg(6'(8 * v + 0), freq_fs[v][7:0]);
         write_reg(6'(8 * v + 1), freq_fs[v][15:8]);
         write_reg(6'(8 * v + 2), {1'b0, 3'd7, freq_fs[v][19:16]});
         write_reg(6'(8 * v + 3), 8'h0F);
      end
      exp_acc7 = '0;
      for (int f = 1; f <= 4; f++) begin
         wait_cnt(8'd33);
         exp_acc7 = exp_acc7 + freq_fs[7];
         n_checks++;
         if (sout !== 8'd225) begin n_fail++; $display("FAIL full_scale: frame %0d got %0d required 225", f, sout); end
         n_checks++;
         if (wave_ad !== {3'd7, exp_acc7[19:15]}) begin
            n_fail++;
            $display("FAIL full_scale_wave_ad: frame %0d got %0h required %0h", f, wave_ad, {3'd7, exp_acc7[19:15]});
         end
      end
   endtask

   // Continues from test_full_scale without reset; we are at cnt 33.
   task automatic test_enable_off();
      logic [7:0] exp;
      snd_enable = 1'b0;
      for (int f = 0; f < 3; f++) begin
         if (f == 2) snd_enable = 1'b1;
         wait_cnt(8'd33);
         exp_acc7 = exp_acc7 + freq_fs[7];
         exp = (f < 2) ? 8'd0 : 8'd225;
         n_checks++;
         if (sout !== exp) begin n_fail++; $display("FAIL enable_sout: step %0d got %0d required %0d", f, sout, exp); end
         n_checks++;
         if (wave_ad !== {3'd7, exp_acc7[19:15]}) begin
            n_fail++;
            $display("FAIL enable_wave_ad: step %0d got %0h required %0h", f, wave_ad, {3'd7, exp_acc7[19:15]});
         end
      end
   endtask

   task automatic test_mid_reset();
      wait_cnt(8'd12);
      n_reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sout !== 8'h00) begin n_fail++; $display("FAIL mid_reset_sout: got %0d required 0", sout); end
      n_checks++;
      if (wave_ad !== 8'h00) begin n_fail++; $display("FAIL mid_reset_wave_ad: got %0h required 0", wave_ad); end
      n_checks++;
      if (dut.cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d required 0", dut.cnt); end
      n_reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut.cnt !== 8'd1) begin n_fail++; $display("FAIL mid_reset_restart: got %0d required 1", dut.cnt); end
      for (int f = 0; f < 2; f++) begin
         wait_cnt(8'd33);
         n_checks++;
         if (sout !== 8'h00) begin n_fail++; $display("FAIL mid_reset_cleared: frame %0d got %0d required 0", f, sout); end
      end
   endtask

   task automatic test_write_edge();
      wait_cnt(8'd40);
      write_reg(6'h02, 8'h70);
      addr = 6'h03;
      data = 8'h05;
      we   = 1'b1;
      repeat (4) @(negedge clk);
      data = 8'h0A;
      repeat (6) @(negedge clk);
      we = 1'b0;
      @(negedge clk);
      wait_cnt(8'd33);
      n_checks++;
      if (sout !== 8'd9) begin n_fail++; $display("FAIL write_edge_vol: got %0d required 9", sout); end
      wait_cnt(8'd2);
      n_checks++;
      if (wave_ad !== 8'hE0) begin n_fail++; $display("FAIL write_edge_wave_ad: got %0h required e0", wave_ad); end
      wait_cnt(8'd40);
      for (int a = 4; a < 8; a++) write_reg(6'(a), 8'hFF);
      wait_cnt(8'd33);
      n_checks++;
      if (sout !== 8'd9) begin n_fail++; $display("FAIL unused_offset_sout: got %0d required 9", sout); end
      wait_cnt(8'd2);
      n_checks++;
      if (wave_ad !== 8'hE0) begin n_fail++; $display("FAIL unused_offset_wave_ad: got %0h required e0", wave_ad); end
   endtask

   task automatic test_wrap();
      logic [19:0] exp_acc;
      do_reset();
      wait_cnt(8'd40);
      write_reg(6'h00, 8'hFF);
      write_reg(6'h01, 8'hFF);
      write_reg(6'h02, 8'h0F);
      exp_acc = 20'hFFFFF;
      for (int f = 1; f <= 2; f++) begin
         wait_cnt(8'd2);
         n_checks++;
         if (dut.acc[0] !== exp_acc) begin
            n_fail++;
            $display("FAIL wrap_acc: frame %0d got %0h required %0h", f, dut.acc[0], exp_acc);
         end
         n_checks++;
         if (wave_ad !== 8'h1F) begin n_fail++; $display("FAIL wrap_wave_ad: frame %0d got %0h required 1f", f, wave_ad); end
         exp_acc = exp_acc + 20'hFFFFF;
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      n_reset    = 1'b0;
      addr       = '0;
      data       = '0;
      we         = 1'b0;
      snd_enable = 1'b1;
      wave_dt    = '0;
      for (int i = 0; i < 256; i++) begin
         if ((i >> 5) == 0)      rom[i] = 4'(ramp(i & 31));
         else if ((i >> 5) == 7) rom[i] = 4'hF;
         else                    rom[i] = 4'(i & 3);
      end
      test_reset();
      test_single_voice();
      test_full_scale();
      test_enable_off();
      test_mid_reset();
      test_write_edge();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
